// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame geometry and a vote helper.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: oversampling strobe and serial line in, received byte and status out.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) ();

  logic                 rx_tick;
  logic                 rx_in;
  logic [0:DATA_BITS-1] data_out;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;

  modport slave (
    input  rx_tick, rx_in,
    output data_out, rx_done, rx_busy, frame_err
  );

  modport master (
    output rx_tick, rx_in,
    input  data_out, rx_done, rx_busy, frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: majority-of-three sampling around mid-bit on the oversampling strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input logic    clk,
  input logic    rst,
  uart_rx_if.slave rx
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 armed, armed_next;
  logic [SW-1:0]        sample_cnt, sample_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [0:DATA_BITS-1] shift_reg, shift_next;
  logic [0:DATA_BITS-1] data_q, data_next;
  logic [1:0]           hist, hist_next;
  logic                 ferr_q, ferr_next;
  logic                 busy_q, busy_next;
  logic                 done_q, done_next;
  logic                 rx_s;
  logic                 vote;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rx.rx_in),
    .dout (rx_s)
  );

  // hist[1] holds the MID-1 sample and hist[0] the MID sample; the live sample completes the vote
  assign vote = majority3(hist[1], hist[0], rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RX_IDLE;
      armed      <= 1'b0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_q     <= '0;
      hist       <= '0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      armed      <= armed_next;
      sample_cnt <= sample_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      data_q     <= data_next;
      hist       <= hist_next;
      ferr_q     <= ferr_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    armed_next  = armed;
    sample_next = sample_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    data_next   = data_q;
    hist_next   = hist;
    ferr_next   = ferr_q;
    busy_next   = busy_q;
    done_next   = 1'b0;

    if (rx.rx_tick) begin
      case (state)
        RX_IDLE: begin
          sample_next = '0;
          if (rx_s) begin
            armed_next = 1'b1;
          end else if (armed) begin
            // the detecting tick counts as sample 0 of the start bit
            state_next  = RX_START;
            sample_next = SW'(1);
            busy_next   = 1'b1;
          end
        end
        default: begin
          sample_next = (sample_cnt == S_LAST) ? '0 : sample_cnt + 1'b1;
          if (sample_cnt == S_LO)  hist_next[1] = rx_s;
          if (sample_cnt == S_MID) hist_next[0] = rx_s;
          case (state)
            RX_START: begin
              if (sample_cnt == S_DEC && vote) begin
                state_next  = RX_IDLE;
                busy_next   = 1'b0;
                sample_next = '0;
              end else if (sample_cnt == S_LAST) begin
                state_next = RX_DATA;
                bit_next   = '0;
              end
            end
            RX_DATA: begin
              if (sample_cnt == S_DEC) shift_next[bit_cnt] = vote;
              if (sample_cnt == S_LAST) begin
                if (bit_cnt == B_LAST) state_next = RX_STOP;
                else                   bit_next   = bit_cnt + 1'b1;
              end
            end
            RX_STOP: begin
              // leave at the stop decision rather than the bit end to gain resync margin
              if (sample_cnt == S_DEC) begin
                data_next   = shift_reg;
                ferr_next   = ~vote;
                armed_next  = vote;
                busy_next   = 1'b0;
                done_next   = 1'b1;
                sample_next = '0;
                state_next  = RX_IDLE;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign rx.data_out  = data_q;
  assign rx.rx_done   = done_q;
  assign rx.rx_busy   = busy_q;
  assign rx.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner sequences and random frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = 16;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } res_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         tper;
    int         gap;
    int         glitch;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   tick_per   = 4;
  logic tick_on    = 1'b0;
  int   tick_cnt   = 0;
  res_t got_q[$];
  res_t exp_q[$];
  vec_t vecs[$];

  uart_rx_if #(.DATA_BITS(8)) rif ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rif.slave)
  );

  initial forever #5 clk = ~clk;

  initial begin
    rif.rx_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      rif.rx_tick = tick_on && (tick_cnt % tick_per == 0);
    end
  end

  function automatic logic [7:0] outByte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = rif.data_out[i];
    return b;
  endfunction

  initial forever begin
    @(negedge clk);
    #1;
    if (rif.rx_done === 1'b1) got_q.push_back({rif.frame_err, outByte()});
  end

  // Wire-level model: bits[0] is the start bit, bits[1..8] data LSB first, bits[9] the stop bit
  function automatic res_t refModel(input logic bits[$]);
    res_t r;
    for (int i = 0; i < 8; i++) r.data[i] = bits[i + 1];
    r.ferr = ~bits[9];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic v, input int clks);
    rif.rx_in = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stop, input int bclk,
                           input int glitch, input res_t exp);
    exp_q.push_back(exp);
    sendBit(1'b0, bclk);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        sendBit(d[i], bclk / 2 - 2);
        sendBit(1'b0, tick_per);
        sendBit(d[i], bclk - bclk / 2 + 2 - tick_per);
      end else begin
        sendBit(d[i], bclk);
      end
    end
    sendBit(stop, bclk);
  endtask

  task automatic checkOutput(input string name);
    res_t g, e;
    check({name, " done count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({name, " data"}, g.data, e.data);
      check({name, " frame_err"}, g.ferr, e.ferr);
    end
    check({name, " busy idle"}, rif.rx_busy, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    tick_per = v.tper;
    sendFrame(v.data, v.stop, v.bclk, v.glitch, v.exp);
    sendBit(1'b1, v.gap * v.bclk);
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, " data_out"}, outByte(), 0);
    check({name, " rx_done"}, rif.rx_done, 0);
    check({name, " rx_busy"}, rif.rx_busy, 0);
    check({name, " frame_err"}, rif.frame_err, 0);
  endtask

  initial begin
    logic bits[$];
    logic [7:0] d;
    logic       s;
    int         per;
    vec_t       v;

    vecs.push_back('{8'h35, 1'b1, 64, 4, 2, -1, '{1'b0, 8'h35}});
    vecs.push_back('{8'hFF, 1'b1, 64, 4, 2,  3, '{1'b0, 8'hFF}});
    vecs.push_back('{8'h01, 1'b1, 66, 4, 0, -1, '{1'b0, 8'h01}});
    vecs.push_back('{8'h80, 1'b1, 66, 4, 2, -1, '{1'b0, 8'h80}});
    vecs.push_back('{8'h01, 1'b1, 62, 4, 0, -1, '{1'b0, 8'h01}});
    vecs.push_back('{8'h80, 1'b1, 62, 4, 2, -1, '{1'b0, 8'h80}});
    vecs.push_back('{8'h96, 1'b1, 16, 1, 2, -1, '{1'b0, 8'h96}});
    vecs.push_back('{8'h3C, 1'b0, 64, 4, 2, -1, '{1'b1, 8'h3C}});

    rst       = 1'b0;
    rif.rx_in = 1'b1;
    repeat (5) @(negedge clk);
    checkResetOutputs("reset");
    rst     = 1'b1;
    tick_on = 1'b1;
    sendBit(1'b1, 128);

    // Without ticks a low line must not start a frame
    tick_on = 1'b0;
    sendBit(1'b0, 200);
    check("no tick busy", rif.rx_busy, 0);
    sendBit(1'b1, 20);
    tick_on = 1'b1;
    sendBit(1'b1, 64);
    checkOutput("no tick");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end
    tick_per = 4;
    sendBit(1'b1, 64);

    sendBit(1'b0, 5 * tick_per);
    check("false start busy", rif.rx_busy, 1);
    sendBit(1'b1, 128);
    checkOutput("false start");
    sendFrame(8'hA5, 1'b1, 64, -1, '{1'b0, 8'hA5});
    sendBit(1'b1, 128);
    checkOutput("after false start");

    sendFrame(8'h00, 1'b0, 64, -1, '{1'b1, 8'h00});
    sendBit(1'b0, 40 * 64);
    checkOutput("break");
    sendBit(1'b1, 64);
    sendFrame(8'h5A, 1'b1, 64, -1, '{1'b0, 8'h5A});
    sendBit(1'b1, 128);
    checkOutput("after break");

    d = 8'h6B;
    sendBit(1'b0, 64);
    for (int i = 0; i < 4; i++) sendBit(d[i], 64);
    sendBit(d[4], 32);
    check("pre-reset busy", rif.rx_busy, 1);
    rst = 1'b0;
    #1;
    checkResetOutputs("mid-frame reset");
    rif.rx_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sendBit(1'b1, 128);
    checkOutput("abandoned frame");
    sendFrame(8'hC3, 1'b1, 64, -1, '{1'b0, 8'hC3});
    sendBit(1'b1, 128);
    checkOutput("after reset");

    for (int n = 0; n < 10; n++) begin
      d   = 8'($urandom);
      s   = ($urandom_range(0, 3) != 0);
      per = ($urandom_range(0, 1) == 0) ? 1 : 4;
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      bits.push_back(s);
      v = '{d, s, OS * per, per, 2, -1, refModel(bits)};
      applyStimulus(v);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
